wav_dfi_upd_ctrl: RTL and testbench

PHY-side DFI update handshake controller sitting directly behind the DFI boundary. It answers MC-initiated updates (ctrlupd_req/ctrlupd_ack) and originates PHY-initiated updates (phyupd_req/phyupd_type/phyupd_ack) on request from PHY calibration logic. It guarantees that the two update types never overlap and that every signal it drives satisfies the DFI update protocol checks enforced on the DFI interface. It also gives PHY internals a busy window and done/error pulses.

---
 rtl/wav_dfi_upd_pkg.sv | 29 ++
 rtl/wav_dfi_upd_cnt.sv | 33 +++
 rtl/wav_dfi_upd_ctrl.sv | 172 +++++++++++++++++
 tb/tb_wav_dfi_upd_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wav_dfi_upd_pkg.sv
// Shared state encoding, update-type codes and default timing for the
// PHY-side DFI update handshake controller.
package wav_dfi_upd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CTRL_ACK,
        PHY_REQ,
        PHY_UPD,
        PHY_REL
    } upd_state_t;

    localparam logic [1:0] TYPE0 = 2'd0;
    localparam logic [1:0] TYPE1 = 2'd1;
    localparam logic [1:0] TYPE2 = 2'd2;
    localparam logic [1:0] TYPE3 = 2'd3;

    // TPHYUPD_RESP_DEF must track the tphyupd_resp value the bench assumes.
    localparam int TPHYUPD_RESP_DEF = 16;
    localparam int TPHYUPD_DUR_DEF  = 12;
    localparam int TCTRLUPD_MIN_DEF = 2;

    function automatic int cnt_width(input int resp, input int dur);
        int m;
        m = (resp > dur) ? resp : dur;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/wav_dfi_upd_cnt.sv
// Loadable saturating up/down counter with zero flag, shared by the
// response wait, the update duration and the ctrl window length.
module wav_dfi_upd_cnt
    import wav_dfi_upd_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Load has priority; counting stops at either end instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/wav_dfi_upd_ctrl.sv
// DFI update handshake controller: acknowledges MC ctrl updates, raises PHY
// updates on request and keeps the two windows from ever overlapping.
module wav_dfi_upd_ctrl
    import wav_dfi_upd_pkg::*;
#(
    parameter int TPHYUPD_RESP = TPHYUPD_RESP_DEF,
    parameter int TPHYUPD_DUR  = TPHYUPD_DUR_DEF,
    parameter int TCTRLUPD_MIN = TCTRLUPD_MIN_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ctrlupd_req,
    output logic       ctrlupd_ack,
    output logic       phyupd_req,
    output logic [1:0] phyupd_type,
    input  logic       phyupd_ack,
    input  logic       upd_pending,
    input  logic [1:0] upd_type_in,
    output logic       upd_busy,
    output logic       ctrl_upd_ok,
    output logic       upd_done,
    output logic       upd_timeout,
    output logic       proto_err
);

    localparam int CNT_W = cnt_width(TPHYUPD_RESP, TPHYUPD_DUR);
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(TPHYUPD_RESP - 1);
    localparam logic [CNT_W-1:0] DUR_LOAD  = CNT_W'(TPHYUPD_DUR - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    upd_state_t state;
    logic       ack_reg;
    logic       ok_reg;
    logic       req_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       tmo_reg;
    logic       perr_reg;
    logic [1:0] type_reg;

    logic             cnt_load;
    logic             cnt_inc;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_val;

    wav_dfi_upd_cnt #(.WIDTH(CNT_W)) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    // The response wait starts at 1 so the count equals the number of
    // cycles phyupd_req has been visible to the MC.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_inc      = 1'b0;
        cnt_dec      = 1'b0;
        case (state)
            IDLE: begin
                if (ctrlupd_req) begin
                    cnt_load = 1'b1;
                end else if (upd_pending && !phyupd_ack) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_ONE;
                end
            end
            CTRL_ACK: cnt_inc = 1'b1;
            PHY_REQ: begin
                if (phyupd_ack) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = DUR_LOAD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            PHY_UPD: cnt_dec = 1'b1;
            default: ;
        endcase
    end

    // upd_done is raised one cycle early so it shares the last busy cycle,
    // letting phyupd_req drop in the cycle right after the pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ack_reg  <= 1'b0;
            ok_reg   <= 1'b0;
            req_reg  <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            tmo_reg  <= 1'b0;
            perr_reg <= 1'b0;
            type_reg <= TYPE0;
        end else begin
            done_reg <= 1'b0;
            tmo_reg  <= 1'b0;
            perr_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrlupd_req) begin
                        state    <= CTRL_ACK;
                        ack_reg  <= 1'b1;
                        busy_reg <= 1'b1;
                        ok_reg   <= (TCTRLUPD_MIN == 0);
                    end else if (upd_pending && !phyupd_ack) begin
                        state    <= PHY_REQ;
                        req_reg  <= 1'b1;
                        type_reg <= upd_type_in;
                        tmo_reg  <= (TPHYUPD_RESP == 1);
                    end
                end
                CTRL_ACK: begin
                    if (!ctrlupd_req) begin
                        state    <= IDLE;
                        ack_reg  <= 1'b0;
                        ok_reg   <= 1'b0;
                        busy_reg <= 1'b0;
                    end else begin
                        ok_reg <= ((int'(cnt_val) + 1) >= TCTRLUPD_MIN);
                    end
                end
                PHY_REQ: begin
                    if (phyupd_ack) begin
                        state    <= PHY_UPD;
                        busy_reg <= 1'b1;
                        done_reg <= (TPHYUPD_DUR == 1);
                    end else if (cnt_val == RESP_LAST) begin
                        tmo_reg <= 1'b1;
                    end
                end
                PHY_UPD: begin
                    if (cnt_zero) begin
                        state    <= PHY_REL;
                        req_reg  <= 1'b0;
                        busy_reg <= 1'b0;
                    end else if (!phyupd_ack) begin
                        state    <= PHY_REL;
                        req_reg  <= 1'b0;
                        busy_reg <= 1'b0;
                        perr_reg <= 1'b1;
                    end else if (cnt_val == CNT_ONE) begin
                        done_reg <= 1'b1;
                    end
                end
                PHY_REL: begin
                    if (!phyupd_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ctrlupd_ack = ack_reg & ctrlupd_req;
    assign ctrl_upd_ok = ok_reg & ctrlupd_req;
    assign phyupd_req  = req_reg;
    assign phyupd_type = type_reg;
    assign upd_busy    = busy_reg;
    assign upd_done    = done_reg;
    assign upd_timeout = tmo_reg;
    assign proto_err   = perr_reg;

endmodule

// File: tb/tb_wav_dfi_upd_ctrl.sv
// Cycle-accurate bench for wav_dfi_upd_ctrl: per-cycle expected outputs are
// queued as stimulus is driven and compared when the outputs are sampled.
`define TPHYUPD_RESP 16

module tb_wav_dfi_upd_ctrl;
    import wav_dfi_upd_pkg::*;

    localparam int RESP = `TPHYUPD_RESP;
    localparam int DUR  = 12;
    localparam int MIN  = 2;

    typedef struct packed {
        logic       ack;
        logic       ok;
        logic       preq;
        logic [1:0] ptype;
        logic       busy;
        logic       done;
        logic       tmo;
        logic       perr;
    } out_t;

    logic       clock;
    logic       reset;
    logic       ctrlupd_req;
    logic       ctrlupd_ack;
    logic       phyupd_req;
    logic [1:0] phyupd_type;
    logic       phyupd_ack;
    logic       upd_pending;
    logic [1:0] upd_type_in;
    logic       upd_busy;
    logic       ctrl_upd_ok;
    logic       upd_done;
    logic       upd_timeout;
    logic       proto_err;

    int   errors = 0;
    int   checks = 0;
    out_t expQ[$];

    wav_dfi_upd_ctrl #(
        .TPHYUPD_RESP (RESP),
        .TPHYUPD_DUR  (DUR),
        .TCTRLUPD_MIN (MIN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ctrlupd_req (ctrlupd_req),
        .ctrlupd_ack (ctrlupd_ack),
        .phyupd_req  (phyupd_req),
        .phyupd_type (phyupd_type),
        .phyupd_ack  (phyupd_ack),
        .upd_pending (upd_pending),
        .upd_type_in (upd_type_in),
        .upd_busy    (upd_busy),
        .ctrl_upd_ok (ctrl_upd_ok),
        .upd_done    (upd_done),
        .upd_timeout (upd_timeout),
        .proto_err   (proto_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // phyupd_type only carries meaning while phyupd_req is high.
    function automatic out_t sampleOut();
        out_t s;
        s.ack   = ctrlupd_ack;
        s.ok    = ctrl_upd_ok;
        s.preq  = phyupd_req;
        s.ptype = phyupd_req ? phyupd_type : 2'd0;
        s.busy  = upd_busy;
        s.done  = upd_done;
        s.tmo   = upd_timeout;
        s.perr  = proto_err;
        return s;
    endfunction

    // Expected PHY-update outputs in cycle c: req first visible in 'rise',
    // MC ack first sampled in cycle 'a'.
    function automatic out_t expPhy(int c, int rise, int a, logic [1:0] t);
        out_t e = '0;
        int last = a + DUR;
        e.preq  = (c >= rise) && (c <= last);
        e.ptype = e.preq ? t : 2'd0;
        e.busy  = (c > a) && (c <= last);
        e.done  = (c == last);
        e.tmo   = (c == rise + RESP - 1) && (a >= rise + RESP - 1);
        return e;
    endfunction

    // Cycle c spans the posedge before it to the posedge ending it.
    task automatic applyStimulus(input logic creq, input logic pend,
                                 input logic [1:0] t, input logic pack);
        @(posedge clock);
        #1;
        ctrlupd_req = creq;
        upd_pending = pend;
        upd_type_in = t;
        phyupd_ack  = pack;
        @(negedge clock);
    endtask

    task automatic test_reset();
        out_t obs, want;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        obs = sampleOut();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_hold got=%b want=%b", obs, out_t'(0));
        end
        checks++;
        if (phyupd_type !== TYPE0) begin
            errors++;
            $display("[TB] FAIL reset_type got=%0d want=0", phyupd_type);
        end
        reset = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            expQ.push_back('0);
            applyStimulus(1'b0, 1'b0, TYPE0, 1'b0);
            obs  = sampleOut();
            want = expQ.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL reset_idle c=%0d got=%b want=%b", c, obs, want);
            end
        end
    endtask

    task automatic test_ctrl_update();
        out_t obs, want, e;
        for (int c = 1; c <= 13; c++) begin
            e      = '0;
            e.ack  = (c >= 2) && (c <= 10);
            e.ok   = (c >= 2 + MIN) && (c <= 10);
            e.busy = (c >= 2) && (c <= 11);
            expQ.push_back(e);
            applyStimulus(c <= 10, 1'b0, TYPE0, 1'b0);
            obs  = sampleOut();
            want = expQ.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL ctrl_update c=%0d got=%b want=%b", c, obs, want);
            end
        end
    endtask

    task automatic test_phy_update();
        out_t obs, want;
        for (int c = 1; c <= 21; c++) begin
            expQ.push_back(expPhy(c, 2, 5, TYPE2));
            applyStimulus(1'b0, c <= 3, TYPE2, (c >= 5) && (c <= 18));
            obs  = sampleOut();
            want = expQ.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL phy_update c=%0d got=%b want=%b", c, obs, want);
            end
        end
    endtask

    task automatic test_timeout();
        out_t obs, want;
        for (int c = 1; c <= 36; c++) begin
            expQ.push_back(expPhy(c, 2, 21, TYPE1));
            applyStimulus(1'b0, c == 1, TYPE1, (c >= 21) && (c <= 34));
            obs  = sampleOut();
            want = expQ.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL timeout c=%0d got=%b want=%b", c, obs, want);
            end
        end
    endtask

    // A second ctrlupd_req burst lands in PHY_UPD and must be ignored.
    task automatic test_arbitration();
        out_t obs, want, e;
        for (int c = 1; c <= 26; c++) begin
            e     = expPhy(c, 9, 11, TYPE3);
            e.ack = (c >= 2) && (c <= 6);
            e.ok  = (c >= 2 + MIN) && (c <= 6);
            if ((c >= 2) && (c <= 7)) e.busy = 1'b1;
            expQ.push_back(e);
            applyStimulus((c <= 6) || (c == 14) || (c == 15), c <= 9, TYPE3,
                          (c >= 11) && (c <= 24));
            obs  = sampleOut();
            want = expQ.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL arbitration c=%0d got=%b want=%b", c, obs, want);
            end
        end
    endtask

    task automatic test_proto_err();
        out_t obs, want, e;
        for (int c = 1; c <= 13; c++) begin
            e       = '0;
            e.preq  = ((c >= 2) && (c <= 9)) || (c >= 12);
            e.ptype = !e.preq ? 2'd0 : ((c >= 12) ? TYPE3 : TYPE1);
            e.busy  = (c >= 5) && (c <= 9);
            e.perr  = (c == 10);
            expQ.push_back(e);
            applyStimulus(1'b0, (c == 1) || (c >= 11), (c >= 11) ? TYPE3 : TYPE1,
                          (c >= 4) && (c <= 8));
            obs  = sampleOut();
            want = expQ.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL proto_err c=%0d got=%b want=%b", c, obs, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_t obs, want, e;
        @(negedge clock);
        reset       = 1'b1;
        ctrlupd_req = 1'b0;
        upd_pending = 1'b0;
        phyupd_ack  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            expQ.push_back(expPhy(c, 2, 4, TYPE2));
            applyStimulus(1'b0, 1'b1, TYPE2, c >= 4);
            obs  = sampleOut();
            want = expQ.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL reset_mid_pre c=%0d got=%b want=%b", c, obs, want);
            end
        end
        #2;
        reset      = 1'b1;
        phyupd_ack = 1'b0;
        #1;
        obs = sampleOut();
        checks++;
        if ((obs !== '0) || (phyupd_type !== TYPE0)) begin
            errors++;
            $display("[TB] FAIL reset_async got=%b type=%0d want=%b type=0",
                     obs, phyupd_type, out_t'(0));
        end
        @(negedge clock);
        obs = sampleOut();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_held got=%b want=%b", obs, out_t'(0));
        end
        reset = 1'b0;
        #1;
        obs = sampleOut();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_release got=%b want=%b", obs, out_t'(0));
        end
        e       = '0;
        e.preq  = 1'b1;
        e.ptype = TYPE2;
        expQ.push_back(e);
        @(posedge clock);
        @(negedge clock);
        obs  = sampleOut();
        want = expQ.pop_front();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("[TB] FAIL reset_rerequest got=%b want=%b", obs, want);
        end
    endtask

    initial begin
        reset       = 1'b1;
        ctrlupd_req = 1'b0;
        upd_pending = 1'b0;
        upd_type_in = TYPE0;
        phyupd_ack  = 1'b0;
        $display("[TB] starting wav_dfi_upd_ctrl bench");
        test_reset();
        test_ctrl_update();
        test_phy_update();
        test_timeout();
        test_arbitration();
        test_proto_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
